// File: rtl/xadc_drp_pkg.sv
// Shared definitions for the XADC DRP responder: register map, DRP FSM states
// and the aux result formatting helper.
package xadc_drp_pkg;

    localparam logic [6:0] ADDR_AUX0 = 7'h10;
    localparam logic [6:0] ADDR_AUX1 = 7'h11;
    localparam logic [6:0] ADDR_AUX2 = 7'h12;
    localparam logic [6:0] ADDR_AUX3 = 7'h13;
    localparam logic [6:0] CFG_BASE  = 7'h40;
    localparam logic [6:0] CFG_LAST  = 7'h5F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } drp_state_t;

    // 12-bit conversion results are MSB-justified in the 16-bit DRP word.
    function automatic logic [15:0] fmt_result(input logic [11:0] sample);
        return {sample, 4'h0};
    endfunction

endpackage

// File: rtl/xadc_seq_emulator.sv
// Channel sequencer stand-in: free-running period counter, BUSY/EOS generation
// and the four aux result registers with a read port selected by aux index.
module xadc_seq_emulator
    import xadc_drp_pkg::*;
#(
    parameter int unsigned EOS_PERIOD  = 256,
    parameter int unsigned CONV_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [47:0] i_aux_sample,
    input  logic [1:0]  i_aux_idx,
    output logic [15:0] o_aux_data,
    output logic        o_busy,
    output logic        o_eos
);

    localparam logic [15:0] LAST_COUNT = 16'(EOS_PERIOD - 1);
    localparam logic [15:0] BUSY_START = 16'(EOS_PERIOD - CONV_CYCLES);

    logic [15:0]      r_count;
    logic [15:0]      w_count_next;
    logic [3:0][11:0] r_aux;
    logic             r_busy;
    logic             r_eos;

    assign w_count_next = (r_count == LAST_COUNT) ? 16'd0 : r_count + 16'd1;

    // BUSY/EOS are registered from the next count so they line up with the counter value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
            r_aux   <= '0;
            r_busy  <= 1'b0;
            r_eos   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_busy  <= (w_count_next >= BUSY_START);
            r_eos   <= (w_count_next == LAST_COUNT);
            if (r_count == LAST_COUNT) begin
                r_aux <= i_aux_sample;
            end
        end
    end

    assign o_aux_data = fmt_result(r_aux[i_aux_idx]);
    assign o_busy     = r_busy;
    assign o_eos      = r_eos;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP slave emulation: fixed-latency DRP read/write responder with a
// 32-entry config regfile and aux result registers fed by the sequencer.
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int unsigned DRDY_LATENCY = 4,
    parameter int unsigned EOS_PERIOD   = 256,
    parameter int unsigned CONV_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  DADDR,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DRDY,
    output logic        BUSY,
    output logic        EOS,
    input  logic [47:0] aux_sample,
    output logic        protocol_err
);

    localparam logic [3:0] LAT_INIT = 4'(DRDY_LATENCY - 1);

    drp_state_t        r_state;
    logic [3:0]        r_lat;
    logic [6:0]        r_addr;
    logic              r_we;
    logic [15:0]       r_di;
    logic              r_drdy;
    logic [15:0]       r_do;
    logic              r_perr;
    logic [31:0][15:0] r_cfg;

    logic [15:0]       w_aux_data;
    logic [15:0]       w_rdata;
    logic              w_is_aux;
    logic              w_is_cfg;
    logic [4:0]        w_cfg_idx;

    xadc_seq_emulator #(
        .EOS_PERIOD  (EOS_PERIOD),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_seq (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_aux_sample (aux_sample),
        .i_aux_idx    (r_addr[1:0]),
        .o_aux_data   (w_aux_data),
        .o_busy       (BUSY),
        .o_eos        (EOS)
    );

    assign w_is_aux  = (r_addr >= ADDR_AUX0) && (r_addr <= ADDR_AUX3);
    assign w_is_cfg  = (r_addr >= CFG_BASE) && (r_addr <= CFG_LAST);
    assign w_cfg_idx = r_addr[4:0];

    always_comb begin
        w_rdata = 16'h0000;
        if (w_is_aux) begin
            w_rdata = w_aux_data;
        end else if (w_is_cfg) begin
            w_rdata = r_cfg[w_cfg_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lat   <= 4'd0;
            r_addr  <= 7'd0;
            r_we    <= 1'b0;
            r_di    <= 16'd0;
            r_drdy  <= 1'b0;
            r_do    <= 16'd0;
            r_perr  <= 1'b0;
            r_cfg   <= '0;
        end else begin
            r_drdy <= 1'b0;
            if (DEN && (r_state != ST_IDLE)) begin
                r_perr <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (DEN) begin
                        r_addr <= DADDR;
                        r_we   <= DWE;
                        r_di   <= DI;
                        r_lat  <= LAT_INIT;
                        if (DRDY_LATENCY == 1) begin
                            r_state <= ST_RESPOND;
                            r_drdy  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_lat == 4'd1) begin
                        r_state <= ST_RESPOND;
                        r_drdy  <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                ST_RESPOND: begin
                    // Reads latch the pre-update value; writes leave DO untouched.
                    if (r_we) begin
                        if (w_is_cfg) begin
                            r_cfg[w_cfg_idx] <= r_di;
                        end
                    end else begin
                        r_do <= w_rdata;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign DO           = (r_drdy && !r_we) ? w_rdata : r_do;
    assign DRDY         = r_drdy;
    assign protocol_err = r_perr;

endmodule
